subreg_tim_meas: RTL
====================

# subreg_tim_meas

Pulse-rate measurement block for clock-enable streams such as those produced by the team's subregulation timing divider. It counts enable pulses over a programmable gate window of clock cycles and reports the pulse count and the minimum and maximum pulse-to-pulse gap. Firmware or a self-check bench uses these results to confirm that a generated enable stream has the intended rate and jitter.

## Interface
- C_PERIOD_W, 31: width of the gate length and all result fields.
- CK_i  in  1  system clock; all logic is on the rising edge.
- XARST_i  in  1  asynchronous active-low reset.
- RST_i  in  1  synchronous reset, active high; default 0.
- EN_CK_i  in  1  enable stream under measurement; sampled every cycle.
- START_i  in  1  level; arms one measurement while idle.
- CONT_i  in  1  continuous mode; auto-restart after each window.
- GATE_P_i  in  C_PERIOD_W  gate length in cycles; latched at start.
- BUSY_o  out  1  high during gate cycles.
- DONE_o  out  1  one-cycle strobe; results updated this cycle.
- PULSE_N_o  out  C_PERIOD_W  pulses counted in the last window.
- MIN_GAP_o  out  C_PERIOD_W  smallest gap between consecutive pulses in the window.
- MAX_GAP_o  out  C_PERIOD_W  largest gap between consecutive pulses in the window.

## Operation
- States: IDLE and GATE.
- IDLE -> GATE: START_i=1 and GATE_P_i!=0. GATE_P_i is latched as P. The start with GATE_P_i=0 is ignored and the block stays in IDLE.
- In GATE, a cycle counter runs from 0 to P-1. EN_CK_i is sampled in each of the P gate cycles and nowhere else.
- Pulse count: increments on every sampled EN_CK_i=1. Its maximum is P, so it cannot overflow.
- Gap: the distance in cycles between two consecutive sampled pulses (adjacent pulses give gap 1). The gap counter is reset at each pulse.
  - MIN is updated with the smaller value, MAX with the larger.
  - Gaps are tracked only inside one window. Nothing carries across windows.
- Fewer than 2 pulses in the window: MIN_GAP_o=MAX_GAP_o=0.
- Window end: after gate cycle P-1, the results are written to the outputs and DONE_o pulses.
  - CONT_i=1 in gate cycle P-1: GATE is re-entered directly, P is re-latched from GATE_P_i, and all accumulators are cleared. If GATE_P_i=0 at that point, the block goes to IDLE.
  - Otherwise the block returns to IDLE.
- START_i during GATE is ignored.
- XARST_i low or RST_i high: state IDLE, all counters and outputs 0. Reset mid-window discards the partial window with no DONE_o. RST_i wins over a simultaneous START_i.

## Timing
- Reset values: BUSY_o=0, DONE_o=0, PULSE_N_o=0, MIN_GAP_o=0, MAX_GAP_o=0.
- START_i sampled high at edge t: BUSY_o is high for cycles t+1..t+P, and EN_CK_i is sampled at edges t+1..t+P.
- DONE_o is high for exactly cycle t+P+1. PULSE_N_o, MIN_GAP_o and MAX_GAP_o change only in that cycle and hold until the next DONE_o.
- Continuous mode: BUSY_o stays high with no gap. The next window's gate cycles start at t+P+1, the same cycle as DONE_o.
- Single-shot: BUSY_o=0 in cycle t+P+1. A new START_i is accepted at edge t+P+1 at the earliest.
- Gap arithmetic: C_PERIOD_W bits unsigned. The largest gap is P-1, which always fits.

## Test plan
- EN_CK_i constant 1, GATE_P_i=5, START_i pulse -> DONE_o once, 6 cycles after start, with PULSE_N_o=5, MIN=MAX=1. BUSY_o high for 5 cycles.
- EN_CK_i high every 4th cycle, GATE_P_i=16 -> PULSE_N_o=4, MIN_GAP_o=MAX_GAP_o=4.
- Divider source with PERIOD=7, PULSE_N=3, GATE_P_i=70, single-shot -> PULSE_N_o=30, MIN_GAP_o=2, MAX_GAP_o=3.
- EN_CK_i=0, then a single pulse, GATE_P_i=10 -> first DONE_o gives 0/0/0, second gives 1/0/0. GATE_P_i=0 with START_i -> BUSY_o stays 0.
- CONT_i=1, GATE_P_i=8, then GATE_P_i changed to 4 mid-window -> windows are back-to-back, BUSY_o never drops. The next window lasts 4 cycles and DONE_o spacing changes from 8 to 4.
- XARST_i low, or RST_i high, at gate cycle 3 of 10 -> no DONE_o, outputs 0, state IDLE. RST_i together with START_i -> no start.

Source files
------------

// File: rtl/subreg_tim_meas.sv
// Pulse-rate meter for clock-enable streams: counts enable pulses over a
// programmable gate window and reports pulse count plus min/max pulse gap.
module subreg_tim_meas #(
  parameter int C_PERIOD_W = 31
) (
  input  logic                  CK_i,
  input  logic                  XARST_i,
  input  logic                  RST_i,
  input  logic                  EN_CK_i,
  input  logic                  START_i,
  input  logic                  CONT_i,
  input  logic [C_PERIOD_W-1:0] GATE_P_i,
  output logic                  BUSY_o,
  output logic                  DONE_o,
  output logic [C_PERIOD_W-1:0] PULSE_N_o,
  output logic [C_PERIOD_W-1:0] MIN_GAP_o,
  output logic [C_PERIOD_W-1:0] MAX_GAP_o
);

  localparam logic [C_PERIOD_W-1:0] ONE = {{(C_PERIOD_W-1){1'b0}}, 1'b1};

  typedef enum logic {
    IDLE = 1'b0,
    GATE = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [C_PERIOD_W-1:0] period_q, cyc_q, pulse_q, gap_q, min_q, max_q;
  logic                  seen_q, have_gap_q;

  logic [C_PERIOD_W-1:0] pulse_d, gap_d, min_d, max_d;
  logic                  seen_d, have_gap_d;

  logic sample, last, start, restart, gap_hit;

  assign sample  = (state_q == GATE) && EN_CK_i;
  assign last    = (state_q == GATE) && (cyc_q == period_q - ONE);
  assign start   = (state_q == IDLE) && START_i && (GATE_P_i != '0);
  assign restart = last && CONT_i && (GATE_P_i != '0);
  // A gap exists only once an earlier pulse has been seen in this window.
  assign gap_hit = sample && seen_q;

  assign BUSY_o = (state_q == GATE);

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = GATE;
      GATE: if (last)  state_d = restart ? GATE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i)   state_q <= IDLE;
    else if (RST_i) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // gap_q holds the distance from the last pulse to the current gate cycle.
  always_comb begin
    pulse_d    = sample ? pulse_q + ONE : pulse_q;
    seen_d     = seen_q | sample;
    have_gap_d = have_gap_q | gap_hit;
    min_d      = min_q;
    max_d      = max_q;
    gap_d      = gap_q;
    if (sample)      gap_d = ONE;
    else if (seen_q) gap_d = gap_q + ONE;
    if (gap_hit) begin
      if (!have_gap_q || gap_q < min_q) min_d = gap_q;
      if (!have_gap_q || gap_q > max_q) max_d = gap_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of the others.
  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      period_q   <= '0;
      cyc_q      <= '0;
      pulse_q    <= '0;
      gap_q      <= '0;
      min_q      <= '0;
      max_q      <= '0;
      seen_q     <= 1'b0;
      have_gap_q <= 1'b0;
      DONE_o     <= 1'b0;
      PULSE_N_o  <= '0;
      MIN_GAP_o  <= '0;
      MAX_GAP_o  <= '0;
    end else if (RST_i) begin
      period_q   <= '0;
      cyc_q      <= '0;
      pulse_q    <= '0;
      gap_q      <= '0;
      min_q      <= '0;
      max_q      <= '0;
      seen_q     <= 1'b0;
      have_gap_q <= 1'b0;
      DONE_o     <= 1'b0;
      PULSE_N_o  <= '0;
      MIN_GAP_o  <= '0;
      MAX_GAP_o  <= '0;
    end else begin
      DONE_o <= 1'b0;
      if (start || last) begin
        // Publish the finished window (including its final sample) and
        // clear every accumulator so nothing leaks into the next window.
        if (last) begin
          DONE_o    <= 1'b1;
          PULSE_N_o <= pulse_d;
          MIN_GAP_o <= have_gap_d ? min_d : '0;
          MAX_GAP_o <= have_gap_d ? max_d : '0;
        end
        if (start || restart) period_q <= GATE_P_i;
        cyc_q      <= '0;
        pulse_q    <= '0;
        gap_q      <= '0;
        min_q      <= '0;
        max_q      <= '0;
        seen_q     <= 1'b0;
        have_gap_q <= 1'b0;
      end else if (state_q == GATE) begin
        cyc_q      <= cyc_q + ONE;
        pulse_q    <= pulse_d;
        gap_q      <= gap_d;
        min_q      <= min_d;
        max_q      <= max_d;
        seen_q     <= seen_d;
        have_gap_q <= have_gap_d;
      end
    end
  end

endmodule
